// File: rtl/mux_sweep_pkg.sv
// mux_sweep_pkg: shared state encoding and sizing for the mux truth-table sweeper.
package mux_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int NUM_COMBOS = 8;
    localparam int IDX_W      = 3;

endpackage

// File: rtl/mux_sweep_hold_counter.sv
// mux_sweep_hold_counter: counts 0..HOLD_CYCLES-1 while enabled; last flags the final hold cycle.
module mux_sweep_hold_counter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    generate
        if (HOLD_CYCLES == 1) begin : g_single
            // A single-cycle hold needs no counter: every cycle is the last one.
            logic unused_ctl;
            assign unused_ctl = clr ^ en ^ clk ^ rst_n;
            assign last       = 1'b1;
        end else begin : g_multi
            localparam int CW = $clog2(HOLD_CYCLES);
            localparam logic [CW-1:0] LAST_V = CW'(HOLD_CYCLES - 1);
            logic [CW-1:0] cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt <= '0;
                else if (clr)
                    cnt <= '0;
                else if (en)
                    cnt <= last ? '0 : cnt + 1'b1;
            end
            assign last = (cnt == LAST_V);
        end
    endgenerate

endmodule

// File: rtl/mux_truth_table_sweeper.sv
// mux_truth_table_sweeper: drives {A,B,C} through all 8 combinations and packs sampled Z2 into truth_table.
// Define MUX_SWEEP_COMPARE_EN to add the expected/mismatch/mismatch_mask comparison ports.
module mux_truth_table_sweeper
    import mux_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    input  logic                  Z2,
    output logic [NUM_COMBOS-1:0] truth_table,
`ifdef MUX_SWEEP_COMPARE_EN
    input  logic [NUM_COMBOS-1:0] expected,
    output logic                  mismatch,
    output logic [NUM_COMBOS-1:0] mismatch_mask,
`endif
    output logic                  result_valid,
    input  logic                  result_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COMBOS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] abc;
    logic             hold_last;

    assign {A, B, C} = abc;

    mux_sweep_hold_counter #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state != S_DRIVE),
        .en   (state == S_DRIVE),
        .last (hold_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            abc          <= '0;
            truth_table  <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_DRIVE;
                        idx   <= '0;
                        abc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    // Abort wins over a sample landing on the same edge.
                    if (abort) begin
                        state <= S_IDLE;
                        abc   <= '0;
                        busy  <= 1'b0;
                    end else if (hold_last) begin
                        truth_table[idx] <= Z2;
                        if (idx == LAST_IDX) begin
                            state        <= S_DONE;
                            abc          <= '0;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            abc <= idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        state        <= S_IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    abc          <= '0;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_SWEEP_COMPARE_EN
    logic [NUM_COMBOS-1:0] expected_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            expected_q <= '0;
        else if (state == S_IDLE && start)
            expected_q <= expected;
    end

    assign mismatch_mask = (state == S_DONE) ? (truth_table ^ expected_q) : '0;
    assign mismatch      = |mismatch_mask;
`endif

endmodule
